// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// ALU opcode constants and default widths.
package multdiv_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MULT  = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Decode helper for the X stage: true for R-type mult or div.
    function automatic logic is_multdiv_op(input logic [4:0] opcode, input logic [4:0] alu_op);
        return (opcode == OPC_RTYPE) && ((alu_op == ALU_MULT) || (alu_op == ALU_DIV));
    endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// Sequencer owning the shared iterative multiply/divide unit for the X stage.
// Optional watchdog on the WAIT state is enabled by defining MULTDIV_CTRL_WATCHDOG_EN.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_W       = REG_W_DEF,
    parameter int CYCLE_LIMIT = 40
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic              issue_is_div,
    input  logic [REG_W-1:0]  issue_rd,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic              flush,
    input  logic              wb_ready,
    output logic              stall,
    output logic              md_ctrl_mult,
    output logic              md_ctrl_div,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [REG_W-1:0]  res_rd,
    output logic              res_exc_mult,
    output logic              res_exc_div,
    output logic              busy,
`ifdef MULTDIV_CTRL_WATCHDOG_EN
    output logic              timeout,
`endif
    output state_t            dbg_state
);

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (CYCLE_LIMIT < 1 || CYCLE_LIMIT > 255) begin : g_bad_limit
        $error("multdiv_ctrl: CYCLE_LIMIT must be in 1..255");
    end

    state_t state, next_state;
    logic   is_div_q;
    logic   load_ops;
    logic   capture;
    logic   wd_expire;

`ifdef MULTDIV_CTRL_WATCHDOG_EN
    logic [7:0] wd_cnt;
`endif

    always_comb begin
        next_state = state;
        load_ops   = 1'b0;
        capture    = 1'b0;
        wd_expire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue_valid) begin
                    next_state = ST_START;
                    load_ops   = 1'b1;
                end
            end
            ST_START: next_state = ST_WAIT;
            ST_WAIT: begin
                if (md_ready) begin
                    next_state = ST_DONE;
                    capture    = 1'b1;
                end
`ifdef MULTDIV_CTRL_WATCHDOG_EN
                else if (wd_cnt == 8'(CYCLE_LIMIT - 1)) begin
                    next_state = ST_DONE;
                    wd_expire  = 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (wb_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        // Flush overrides everything, including a same-cycle issue or md_ready.
        if (flush) begin
            next_state = ST_IDLE;
            load_ops   = 1'b0;
            capture    = 1'b0;
            wd_expire  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            is_div_q     <= 1'b0;
            md_a         <= '0;
            md_b         <= '0;
            res_rd       <= '0;
            res_data     <= '0;
            res_exc_mult <= 1'b0;
            res_exc_div  <= 1'b0;
        end else begin
            state <= next_state;
            if (load_ops) begin
                is_div_q <= issue_is_div;
                md_a     <= issue_a;
                md_b     <= issue_b;
                res_rd   <= issue_rd;
            end
            if (capture) begin
                res_data     <= md_result;
                res_exc_mult <= md_exception && !is_div_q;
                res_exc_div  <= md_exception && is_div_q;
            end else if (wd_expire) begin
                res_data     <= '0;
                res_exc_mult <= !is_div_q;
                res_exc_div  <= is_div_q;
            end
        end
    end

`ifdef MULTDIV_CTRL_WATCHDOG_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (state == ST_WAIT && next_state == ST_WAIT) wd_cnt <= wd_cnt + 8'd1;
            else                                            wd_cnt <= '0;
            if (wd_expire) timeout <= 1'b1;
        end
    end
`endif

    // Result handshake: res_valid holds with res_data/res_rd/res_exc_* stable
    // until wb_ready is seen high in the same cycle; that cycle is the transfer.
    assign res_valid    = (state == ST_DONE);
    assign md_ctrl_mult = (state == ST_START) && !is_div_q && !flush;
    assign md_ctrl_div  = (state == ST_START) && is_div_q && !flush;
    assign busy         = (state != ST_IDLE);
    assign dbg_state    = state;
    assign stall        = ((state == ST_IDLE) && issue_valid && !flush)
                        || (state == ST_START) || (state == ST_WAIT)
                        || ((state == ST_DONE) && !wb_ready);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed plus randomized bench for multdiv_ctrl with a behavioural multdiv
// stand-in and an expected-result queue.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int EW = DW + RW + 2;
`ifdef MULTDIV_CTRL_WATCHDOG_EN
    localparam int CL       = 8;
    localparam int FLUSH_AT = 5;
    localparam int LONG_LAT = 4;
`else
    localparam int CL       = 40;
    localparam int FLUSH_AT = 10;
    localparam int LONG_LAT = 32;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          issue_valid = 1'b0;
    logic          issue_is_div = 1'b0;
    logic [RW-1:0] issue_rd = '0;
    logic [DW-1:0] issue_a = '0;
    logic [DW-1:0] issue_b = '0;
    logic          flush = 1'b0;
    logic          wb_ready = 1'b0;
    logic          stall, md_ctrl_mult, md_ctrl_div;
    logic [DW-1:0] md_a, md_b;
    logic [DW-1:0] md_result = '0;
    logic          md_exception = 1'b0;
    logic          md_ready = 1'b0;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic [RW-1:0] res_rd;
    logic          res_exc_mult, res_exc_div, busy;
    state_t        dbg_state;
`ifdef MULTDIV_CTRL_WATCHDOG_EN
    logic          timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    multdiv_ctrl #(.DATA_W(DW), .REG_W(RW), .CYCLE_LIMIT(CL)) dut (
        .clock(clock), .reset_n(reset_n),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
        .issue_a(issue_a), .issue_b(issue_b), .flush(flush), .wb_ready(wb_ready),
        .stall(stall), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
        .md_a(md_a), .md_b(md_b), .md_result(md_result), .md_exception(md_exception),
        .md_ready(md_ready), .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
        .res_exc_mult(res_exc_mult), .res_exc_div(res_exc_div), .busy(busy),
`ifdef MULTDIV_CTRL_WATCHDOG_EN
        .timeout(timeout),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / safety net ----------------
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [DW-1:0] ref_result(input logic is_div, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (is_div) return (b == 0) ? '0 : a / b;
        return p[DW-1:0];
    endfunction

    function automatic logic ref_exc(input logic is_div, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        if (is_div) return (b == 0);
        return (p[63:32] != 0);
    endfunction

    // ---------------- multdiv stand-in: md_ready md_lat cycles after WAIT entry ----------------
    int            md_lat = 1;
    logic          m_active = 1'b0;
    int            m_cnt = 0;
    logic          m_div = 1'b0;
    logic [DW-1:0] m_a = '0, m_b = '0;
    int            n_mult_pulse = 0, n_div_pulse = 0, n_md_ready = 0;

    always @(posedge clock) begin
        md_ready <= 1'b0;
        if (md_ctrl_mult)  n_mult_pulse <= n_mult_pulse + 1;
        if (md_ctrl_div)   n_div_pulse  <= n_div_pulse + 1;
        if (md_ctrl_mult || md_ctrl_div) begin
            m_active <= 1'b1;
            m_cnt    <= md_lat;
            m_div    <= md_ctrl_div;
            m_a      <= md_a;
            m_b      <= md_b;
        end else if (m_active) begin
            if (m_cnt <= 1) begin
                md_ready     <= 1'b1;
                md_result    <= ref_result(m_div, m_a, m_b);
                md_exception <= ref_exc(m_div, m_a, m_b);
                m_active     <= 1'b0;
                n_md_ready   <= n_md_ready + 1;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Caller is positioned at a negedge with the DUT idle; returns at the
    // negedge after the wb_ready transfer, so another op may issue at once.
    task automatic run_op(input logic is_div, input logic [RW-1:0] rd, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input int lat, input int wb_hold,
                          input int exp_cycle, input logic expect_to);
        int mp0, dp0, cyc;
        logic got;
        logic [EW-1:0] e;
        logic ex;
        ex = ref_exc(is_div, a, b);
        if (expect_to) exp_q.push_back({{DW{1'b0}}, rd, !is_div, is_div});
        else           exp_q.push_back({ref_result(is_div, a, b), rd, ex && !is_div, ex && is_div});
        md_lat = lat;
        mp0 = n_mult_pulse;
        dp0 = n_div_pulse;
        issue_valid = 1'b1; issue_is_div = is_div; issue_rd = rd; issue_a = a; issue_b = b;
        #1 check("issue_stall", stall, 1'b1);
        @(negedge clock);
        issue_valid = 1'b0; issue_a = $urandom; issue_b = $urandom; issue_rd = RW'($urandom);
        check("start_pulse", {md_ctrl_mult, md_ctrl_div}, is_div ? 2'b01 : 2'b10);
        check("md_operands", {md_a, md_b}, {a, b});
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (res_valid) got = 1'b1;
        end
        e = exp_q.pop_front();
        check("res_valid_seen", got, 1'b1);
        if (!got) return;
        if (exp_cycle >= 0) check("res_cycle", cyc, exp_cycle);
        check("res_word", {res_data, res_rd, res_exc_mult, res_exc_div}, e);
        for (int i = 0; i < wb_hold; i++) begin
            check("hold_stall", stall, 1'b1);
            @(negedge clock);
            check("hold_word", {res_valid, res_data, res_rd, res_exc_mult, res_exc_div}, {1'b1, e});
        end
        wb_ready = 1'b1;
        #1 check("release_stall", {stall, res_valid}, 2'b01);
        @(negedge clock);
        wb_ready = 1'b0;
        check("idle_after_wb", {busy, res_valid}, 2'b00);
        check("pulse_count", {32'(n_mult_pulse - mp0), 32'(n_div_pulse - dp0)},
              {32'(!is_div), 32'(is_div)});
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int   mp0, dp0, r0;
        logic seen;
        logic d;
        logic [DW-1:0] a, b;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_outputs", {stall, busy, res_valid, md_ctrl_mult, md_ctrl_div}, 5'b0);
        check("rst_regs", {md_a, md_b, res_data, res_rd, res_exc_mult, res_exc_div}, '0);
        check("rst_state", dbg_state, ST_IDLE);
`ifdef MULTDIV_CTRL_WATCHDOG_EN
        check("rst_timeout", timeout, 1'b0);
`endif
        reset_n = 1'b1;
        @(negedge clock);

        // Mult 7 x 6; with a 32-cycle unit the result appears in cycle 35
        run_op(1'b0, 5'd3, 32'd7, 32'd6, LONG_LAT, 0, LONG_LAT + 3, 1'b0);
        // Div by zero: exception routed to the div flag, result still delivered
        run_op(1'b1, 5'd9, 32'd100, 32'd0, 5, 0, 8, 1'b0);
        // Div 100 / 7 with writeback back-pressure for 5 cycles
        run_op(1'b1, 5'd12, 32'd100, 32'd7, 3, 5, 6, 1'b0);
        // Back-to-back mult then div
        run_op(1'b0, 5'd1, 32'd3, 32'd4, 2, 0, 5, 1'b0);
        run_op(1'b1, 5'd2, 32'd20, 32'd5, 2, 0, 5, 1'b0);

        // Flush in WAIT; the late md_ready must be ignored
        mp0 = n_mult_pulse; dp0 = n_div_pulse; r0 = n_md_ready;
        md_lat = 32;
        issue_valid = 1'b1; issue_is_div = 1'b1; issue_rd = 5'd4; issue_a = 32'd50; issue_b = 32'd5;
        @(negedge clock);
        issue_valid = 1'b0;
        repeat (FLUSH_AT - 1) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_idle", {busy, dbg_state}, {1'b0, ST_IDLE});
        seen = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (res_valid || busy) seen = 1'b1;
        end
        check("flush_no_result", seen, 1'b0);
        check("flush_stale_ready", 32'(n_md_ready - r0), 32'd1);
        check("flush_pulses", {32'(n_mult_pulse - mp0), 32'(n_div_pulse - dp0)}, {32'd0, 32'd1});

        // Flush wins over a same-cycle issue
        mp0 = n_mult_pulse; dp0 = n_div_pulse;
        issue_valid = 1'b1; flush = 1'b1; issue_is_div = 1'b0;
        #1 check("flush_issue_stall", stall, 1'b0);
        @(negedge clock);
        issue_valid = 1'b0; flush = 1'b0;
        check("flush_issue_busy", busy, 1'b0);
        @(negedge clock);
        check("flush_issue_pulses", 32'(n_mult_pulse - mp0 + n_div_pulse - dp0), 32'd0);

        // Asynchronous reset mid-operation
        md_lat = 32;
        issue_valid = 1'b1; issue_is_div = 1'b0; issue_a = 32'd9; issue_b = 32'd9;
        @(negedge clock);
        issue_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_reset_busy", {busy, stall}, 2'b11);
        reset_n = 1'b0;
        #1 check("mid_reset", {busy, stall, res_valid}, 3'b000);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);

`ifdef MULTDIV_CTRL_WATCHDOG_EN
        // Watchdog: no md_ready within CL WAIT cycles
        run_op(1'b0, 5'd7, 32'd5, 32'd5, 60, 0, CL + 2, 1'b1);
        check("timeout_set", timeout, 1'b1);
        repeat (70) @(negedge clock);
        run_op(1'b1, 5'd8, 32'd81, 32'd9, 2, 0, 5, 1'b0);
        check("timeout_sticky", timeout, 1'b1);
`endif

        // Randomized operations
        for (int i = 0; i < 16; i++) begin
            d = 1'(($urandom_range(0, 1)));
            a = (i % 3 == 0) ? $urandom : $urandom_range(0, 65535);
            b = ($urandom_range(0, 3) == 0) ? '0 : ((i % 2 == 0) ? $urandom : $urandom_range(1, 300));
            run_op(d, RW'($urandom), a, b, $urandom_range(1, 6), $urandom_range(0, 3), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
